// File: rtl/camera_dvp_capture.sv
// ---------------------------------------------------------------------------
// camera_dvp_capture
//
// Front-end for an OV-series DVP camera running on the camera PCLK.
// Pairs the 8-bit bus bytes of each line into RGB565 pixels, truncates them
// to RGB444 and writes them out as a vde/vsync/data stream for the
// frame-buffer BRAM writer. The first SKIP_FRAMES frames after reset are
// discarded while the sensor settles, and every captured frame is cropped to
// IMAGE_SIZE_H x IMAGE_SIZE_V.
//
// Optional build macro:
//   CAPTURE_TESTPATTERN_EN - replace the pixel data with 8 vertical colour
//                            bars selected by x[8:6]; timing, vde, crop and
//                            error logic are unchanged.
//
// Parameters:
//   IMAGE_SIZE_H  active pixels per output line (excess dropped)
//   IMAGE_SIZE_V  active lines per output frame (excess dropped)
//   SKIP_FRAMES   frames discarded after reset (0 = none)
//
// Ports:
//   i_clk           camera PCLK, rising edge
//   i_rst           asynchronous active-high reset
//   i_cam_vsync     camera VSYNC, high = vertical blank
//   i_cam_href      camera HREF, high = line bytes valid
//   i_cam_data[7:0] camera data byte
//   o_rgb565_vde    pixel valid (downstream write enable)
//   o_rgb565_vsync  low = frame boundary, high = active frame
//   o_rgb565_data   {R[4:1],G[5:2],B[4:1]}
//   o_frame_done    one-cycle pulse at end of each captured frame
//   o_frame_cnt     captured-frame counter, wraps
//   o_line_err      sticky: odd byte count, short line or short frame
//   o_dbg_state     current FSM state (0 skip, 1 wait, 2 active)
//
// Output stream: there is no back-pressure. o_rgb565_vde is a one-cycle
// valid that qualifies o_rgb565_data; the downstream writer must accept every
// cycle in which vde is high. vde is never high on two consecutive cycles and
// data holds its last value while vde is low.
// ---------------------------------------------------------------------------
module camera_dvp_capture #(
  parameter logic [15:0] IMAGE_SIZE_H = 16'd512,
  parameter logic [15:0] IMAGE_SIZE_V = 16'd384,
  parameter logic [7:0]  SKIP_FRAMES  = 8'd10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cam_vsync,
  input  logic        i_cam_href,
  input  logic [7:0]  i_cam_data,
  output logic        o_rgb565_vde,
  output logic        o_rgb565_vsync,
  output logic [11:0] o_rgb565_data,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_line_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_SKIP   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (SKIP_FRAMES == 8'd0) ? S_WAIT : S_SKIP;

  // Input (IOB) stage and one-cycle history for edge detection
  logic        vsync_q, href_q;
  logic [7:0]  cam_data_q;
  logic        vsync_prev_q, href_prev_q;

  // Capture state
  state_t      state_q, state_d;
  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;

  // Output registers
  logic        vde_q, vde_d;
  logic [11:0] data_q, data_d;
  logic        vs_out_q, vs_out_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        line_err_q, line_err_d;

  logic        vs_rise, vs_fall, href_fall;
  logic [11:0] pix_data;

  assign vs_rise   =  vsync_q & ~vsync_prev_q;
  assign vs_fall   = ~vsync_q &  vsync_prev_q;
  assign href_fall = ~href_q  &  href_prev_q;

  // Pixel value for the byte pair completing this cycle: byte0_q holds the
  // phase-0 byte {R5,G[5:3]}, cam_data_q the phase-1 byte {G[2:0],B5}.
`ifdef CAPTURE_TESTPATTERN_EN
  always_comb begin
    pix_data = 12'h000;
    case (x_q[8:6])
      3'd0: pix_data = 12'hFFF;
      3'd1: pix_data = 12'hFF0;
      3'd2: pix_data = 12'h0FF;
      3'd3: pix_data = 12'h0F0;
      3'd4: pix_data = 12'hF0F;
      3'd5: pix_data = 12'hF00;
      3'd6: pix_data = 12'h00F;
      default: pix_data = 12'h000;
    endcase
  end
`else
  assign pix_data = {byte0_q[7:4], byte0_q[2:0], cam_data_q[7], cam_data_q[4:1]};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      cam_data_q   <= 8'd0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      state_q      <= RESET_STATE;
      skip_cnt_q   <= 8'd0;
      phase_q      <= 1'b0;
      byte0_q      <= 8'd0;
      x_q          <= 12'd0;
      y_q          <= 12'd0;
      vde_q        <= 1'b0;
      data_q       <= 12'd0;
      vs_out_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
      line_err_q   <= 1'b0;
    end else begin
      vsync_q      <= i_cam_vsync;
      href_q       <= i_cam_href;
      cam_data_q   <= i_cam_data;
      vsync_prev_q <= vsync_q;
      href_prev_q  <= href_q;
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      phase_q      <= phase_d;
      byte0_q      <= byte0_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vde_q        <= vde_d;
      data_q       <= data_d;
      vs_out_q     <= vs_out_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      line_err_q   <= line_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    phase_d      = phase_q;
    byte0_d      = byte0_q;
    x_d          = x_q;
    y_d          = y_q;
    vde_d        = 1'b0;
    data_d       = data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;
    // Downstream vsync follows the camera (inverted) once skipping is over.
    vs_out_d     = (state_q != S_SKIP) & ~vsync_q;

    case (state_q)
      S_SKIP: begin
        if (vs_rise) begin
          if (skip_cnt_q + 8'd1 == SKIP_FRAMES) begin
            state_d    = S_WAIT;
            skip_cnt_d = 8'd0;
          end else begin
            skip_cnt_d = skip_cnt_q + 8'd1;
          end
        end
      end

      S_WAIT: begin
        phase_d = 1'b0;
        x_d     = 12'd0;
        y_d     = 12'd0;
        if (vs_fall) state_d = S_ACTIVE;
      end

      S_ACTIVE: begin
        if (href_q) begin
          if (!phase_q) begin
            byte0_d = cam_data_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (({4'd0, x_q} < IMAGE_SIZE_H) && ({4'd0, y_q} < IMAGE_SIZE_V)) begin
              vde_d  = 1'b1;
              data_d = pix_data;
            end
            // x counts dropped pixels too, so crop is a plain compare.
            if (x_q != 12'hFFF) x_d = x_q + 12'd1;
          end
        end else begin
          phase_d = 1'b0;
          if (href_fall) begin
            // A pending phase-1 byte means an odd byte count: the partial
            // pixel is simply discarded.
            if (phase_q) line_err_d = 1'b1;
            if ({4'd0, x_q} < IMAGE_SIZE_H) line_err_d = 1'b1;
            x_d = 12'd0;
            if (y_q != 12'hFFF) y_d = y_q + 12'd1;
          end
        end

        // Frame end. A pixel completing in the same cycle was emitted above.
        // y_d already includes a line ending in this same cycle.
        if (vs_rise) begin
          state_d      = S_WAIT;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if ({4'd0, y_d} < IMAGE_SIZE_V) line_err_d = 1'b1;
        end
      end

      default: state_d = RESET_STATE;
    endcase
  end

  assign o_rgb565_vde   = vde_q;
  assign o_rgb565_vsync = vs_out_q;
  assign o_rgb565_data  = data_q;
  assign o_frame_done   = frame_done_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_line_err     = line_err_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_camera_dvp_capture.sv
// ---------------------------------------------------------------------------
// tb_camera_dvp_capture
//
// Directed bench for camera_dvp_capture with a reduced image size (8 x 4) and
// SKIP_FRAMES = 2 so that whole frames stay short. Bytes are driven 1 ns after
// each rising edge and outputs are sampled at the same point, i.e. they show
// the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_camera_dvp_capture;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        vde, vs_out, frame_done, line_err;
  logic [11:0] pix;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;

  camera_dvp_capture #(
    .IMAGE_SIZE_H(16'(H)),
    .IMAGE_SIZE_V(16'(V)),
    .SKIP_FRAMES (8'(SKIP))
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cam_vsync   (cam_vsync),
    .i_cam_href    (cam_href),
    .i_cam_data    (cam_data),
    .o_rgb565_vde  (vde),
    .o_rgb565_vsync(vs_out),
    .o_rgb565_data (pix),
    .o_frame_done  (frame_done),
    .o_frame_cnt   (frame_cnt),
    .o_line_err    (line_err),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [11:0] exp_q[$];
  int          vde_cnt  = 0;
  int          done_cnt = 0;
  logic        prev_vde = 1'b0;
  logic        last_vde = 1'b0;
  logic [11:0] last_pix = 12'd0;
  int          line_y   = 0;

  logic [7:0]  b0_t [4] = '{8'hF8, 8'h07, 8'hA5, 8'h3C};
  logic [7:0]  b1_t [4] = '{8'h1F, 8'hE0, 8'h5A, 8'hC3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 12-bit output for a byte pair at column x.
  function automatic logic [11:0] exp_pix(input logic [7:0] b0, input logic [7:0] b1,
                                          input int x);
`ifdef CAPTURE_TESTPATTERN_EN
    logic [2:0] bi;
    bi = 3'(x >> 6);
    case (bi)
      3'd0: return 12'hFFF;
      3'd1: return 12'hFF0;
      3'd2: return 12'h0FF;
      3'd3: return 12'h0F0;
      3'd4: return 12'hF0F;
      3'd5: return 12'hF00;
      3'd6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    logic [15:0] p;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    p = {b0, b1};
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r[4:1], g[5:2], b[4:1]};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: wait for the edge, check outputs, then drive the next inputs.
  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) done_cnt++;
    if (vde === 1'b1) begin
      vde_cnt++;
      chk("vde_back_to_back", prev_vde, 1'b0);
      if (exp_q.size() == 0) chk("vde_unexpected", vde, 1'b0);
      else chk("pix_data", pix, exp_q.pop_front());
    end
    prev_vde  = vde;
    last_vde  = vde;
    last_pix  = pix;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic send_line(input int npix, input bit odd, input bit cap);
    for (int i = 0; i < npix; i++) begin
      if (cap && i < H && line_y < V) exp_q.push_back(exp_pix(b0_t[i % 4], b1_t[i % 4], i));
      tick(1'b0, 1'b1, b0_t[i % 4]);
      tick(1'b0, 1'b1, b1_t[i % 4]);
    end
    if (odd) tick(1'b0, 1'b1, 8'h55);
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    line_y++;
  endtask

  task automatic vsync_pulse();
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int nlines, input int npix, input bit cap);
    line_y = 0;
    for (int l = 0; l < nlines; l++) send_line(npix, 1'b0, cap);
    vsync_pulse();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]  lb [16];
    logic [11:0] exp_a, exp_b;

    rst = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vde",       vde,        1'b0);
    chk("rst_vsync",     vs_out,     1'b0);
    chk("rst_data",      pix,        12'h000);
    chk("rst_done",      frame_done, 1'b0);
    chk("rst_frame_cnt", frame_cnt,  16'd0);
    chk("rst_line_err",  line_err,   1'b0);
    chk("rst_state",     dbg_state,  2'd0);
    rst = 1'b0;

    // Skipped frames: nothing emitted, state moves to active after the second.
    vde_cnt = 0;
    send_frame(V, H, 1'b0);
    chk("skip1_state", dbg_state, 2'd0);
    chk("skip1_vsync", vs_out,    1'b0);
    send_frame(V, H, 1'b0);
    chk("skip_vde_cnt",   vde_cnt,   0);
    chk("skip_frame_cnt", frame_cnt, 16'd0);
    chk("skip2_state",    dbg_state, 2'd2);
    chk("skip2_vsync",    vs_out,    1'b1);

    // First captured frame.
    vde_cnt = 0;
    send_frame(V, H, 1'b1);
    chk("f3_vde_cnt",   vde_cnt,      H * V);
    chk("f3_frame_cnt", frame_cnt,    16'd1);
    chk("f3_done_cnt",  done_cnt,     1);
    chk("f3_line_err",  line_err,     1'b0);
    chk("f3_exp_empty", exp_q.size(), 0);

    // Oversized frame is cropped without error.
    vde_cnt = 0;
    send_frame(V + 2, H + 2, 1'b1);
    chk("crop_vde_cnt",   vde_cnt,   H * V);
    chk("crop_frame_cnt", frame_cnt, 16'd2);
    chk("crop_line_err",  line_err,  1'b0);

    // Known byte pairs and pipeline latency on line 0.
`ifdef CAPTURE_TESTPATTERN_EN
    exp_a = 12'hFFF;
    exp_b = 12'hFFF;
`else
    exp_a = 12'hF0F;
    exp_b = 12'h0F0;
`endif
    vde_cnt = 0;
    line_y  = 0;
    for (int i = 0; i < H; i++) begin
      lb[2 * i]     = b0_t[i % 4];
      lb[2 * i + 1] = b1_t[i % 4];
      exp_q.push_back(exp_pix(b0_t[i % 4], b1_t[i % 4], i));
    end
    for (int j = 0; j < 2 * H; j++) begin
      tick(1'b0, 1'b1, lb[j]);
      if (j == 2) chk("lat_vde_early", last_vde, 1'b0);
      if (j == 3) begin
        chk("lat_vde_pix0", last_vde, 1'b1);
        chk("data_F8_1F",   last_pix, exp_a);
      end
      if (j == 4) chk("lat_vde_gap", last_vde, 1'b0);
      if (j == 5) begin
        chk("lat_vde_pix1", last_vde, 1'b1);
        chk("data_07_E0",   last_pix, exp_b);
      end
    end
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    line_y = 1;
    for (int l = 1; l < V; l++) send_line(H, 1'b0, 1'b1);
    vsync_pulse();
    chk("f5_vde_cnt",   vde_cnt,   H * V);
    chk("f5_frame_cnt", frame_cnt, 16'd3);
    chk("f5_line_err",  line_err,  1'b0);

    // Odd byte count on line 0: one pixel short, error raised.
    vde_cnt = 0;
    line_y  = 0;
    send_line(H - 1, 1'b1, 1'b1);
    for (int l = 1; l < V; l++) send_line(H, 1'b0, 1'b1);
    vsync_pulse();
    chk("odd_vde_cnt",   vde_cnt,   H * V - 1);
    chk("odd_line_err",  line_err,  1'b1);
    chk("odd_frame_cnt", frame_cnt, 16'd4);

    // Following frame still captured; error stays sticky.
    vde_cnt = 0;
    send_frame(V, H, 1'b1);
    chk("after_vde_cnt",   vde_cnt,   H * V);
    chk("after_frame_cnt", frame_cnt, 16'd5);
    chk("after_line_err",  line_err,  1'b1);
    chk("after_done_cnt",  done_cnt,  5);

    // Reset in the middle of a line.
    tick(1'b0, 1'b1, 8'hF8);
    tick(1'b0, 1'b1, 8'h1F);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_vde",       vde,        1'b0);
    chk("mid_rst_vsync",     vs_out,     1'b0);
    chk("mid_rst_data",      pix,        12'h000);
    chk("mid_rst_done",      frame_done, 1'b0);
    chk("mid_rst_frame_cnt", frame_cnt,  16'd0);
    chk("mid_rst_line_err",  line_err,   1'b0);
    chk("mid_rst_state",     dbg_state,  2'd0);
    cam_href = 1'b0;
    cam_data = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Skip counter restarted: one frame is not enough to leave S_SKIP.
    vde_cnt = 0;
    send_frame(V, H, 1'b0);
    chk("rst_skip_vde_cnt", vde_cnt,   0);
    chk("rst_skip_state",   dbg_state, 2'd0);
    chk("final_exp_empty",  exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
